// File: rtl/neural_engine_pkg.sv
// Shared types and constants for the result-collection path of the neural engine.
// Holds the collector state encoding, the default result-word width, and a
// saturating counter helper used by the drop counter.
package neural_engine_pkg;

    // Default width of a result word leaving the output-selection stage.
    localparam int RESULT_W = 16;

    // Run phases of the result collector.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2,
        DONE    = 2'd3
    } collector_state_t;

    // 8-bit increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/result_collector_fifo.sv
// result_fifo: synchronous show-ahead FIFO for captured result words.
// rdata always shows the word at the read pointer, so the head word is
// visible in the same cycle the FIFO becomes non-empty. A push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle; a pop of
// an empty FIFO is ignored. clear empties the FIFO synchronously and wins
// over push/pop. count is one bit wider than the pointers so that a full
// FIFO and an empty FIFO are distinguishable.
module result_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;

    logic              w_do_push;
    logic              w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_CNT);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];

    // A pop needs a stored word; a push needs a free slot or a same-cycle pop.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push && !clear) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Read/write pointers wrap modulo DEPTH; occupancy tracks push minus pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/result_collector.sv
// result_collector: receive side of the output-selection stage.
// Captures each (in_data, in_ready) strobe into a show-ahead FIFO during a
// run and drains it to the host over an out_valid/out_ack handshake. A start
// pulse arms a run of EXPECT_WORDS strobes; once that many strobes have been
// seen the collector flushes the FIFO and then raises done. Words arriving
// while the FIFO is full (and nothing is popped that cycle) are dropped,
// counted, and flagged through the sticky overflow bit.
// Optional build macro: RESULT_COLLECTOR_CHECKSUM_EN adds a checksum output,
// the running modulo-2^DATA_W sum of every word accepted into the FIFO.
module result_collector
    import neural_engine_pkg::*;
#(
    parameter int DATA_W       = RESULT_W,
    parameter int DEPTH        = 16,
    parameter int EXPECT_WORDS = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ack,
    output logic [7:0]        captured,
    output logic [7:0]        dropped,
    output logic              overflow,
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
    output logic              done,
    output logic [DATA_W-1:0] checksum
`else
    output logic              done
`endif
);

    localparam logic [7:0] EXP_LAST = 8'(EXPECT_WORDS - 1);

    collector_state_t      r_state;
    logic [7:0]            r_captured;
    logic [7:0]            r_dropped;
    logic                  r_overflow;
    logic                  r_done;

    logic                  w_push_req;
    logic                  w_pop_req;
    logic                  w_pop_ok;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_W-1:0]     w_rdata;
    logic [$clog2(DEPTH):0] w_count;

    // Strobes only count while capturing; a start in the same cycle wins.
    assign w_push_req = (r_state == CAPTURE) && in_ready && !start;
    // A start discards whatever word is being acknowledged in that cycle.
    assign w_pop_req  = out_ack && !start;
    assign w_pop_ok   = w_pop_req && !w_empty;
    // Full with no simultaneous pop leaves no room for the incoming word.
    assign w_drop     = w_push_req && w_full && !w_pop_ok;

    result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start),
        .push    (w_push_req),
        .pop     (w_pop_req),
        .wdata   (in_data),
        .rdata   (w_rdata),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // Run control: phase sequencing, strobe/drop counters and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_captured <= 8'd0;
            r_dropped  <= 8'd0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else if (start) begin
            r_state    <= CAPTURE;
            r_captured <= 8'd0;
            r_dropped  <= 8'd0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= IDLE;
                end
                CAPTURE: begin
                    if (w_push_req) begin
                        r_captured <= r_captured + 8'd1;
                        if (w_drop) begin
                            r_dropped  <= sat_inc8(r_dropped);
                            r_overflow <= 1'b1;
                        end
                        if (r_captured == EXP_LAST) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (w_empty) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Head word is forced to zero while nothing is stored, so stale memory
    // contents never appear on the bus.
    assign out_valid = (w_count != '0);
    assign out_data  = w_empty ? '0 : w_rdata;
    assign captured  = r_captured;
    assign dropped   = r_dropped;
    assign overflow  = r_overflow;
    assign done      = r_done;

`ifdef RESULT_COLLECTOR_CHECKSUM_EN
    logic              w_accept;
    logic [DATA_W-1:0] r_checksum;

    // Only words that actually enter the FIFO contribute to the sum.
    assign w_accept = w_push_req && !w_drop;

    // Running modulo-2^DATA_W sum of accepted words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= '0;
        end else if (start) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + in_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Receive-side counterpart of the output-selection stage.
- Captures each (data, ready) strobe produced by mac_core/validator into a FIFO and drains it to an external host over a valid/ack handshake.
- Armed by the system start pulse. Reports completion, overflow and dropped-word count so a bench or host reads every result word exactly once.

Parameters:
- DATA_W, 16, width of captured result words.
- DEPTH, 16, FIFO depth in words; power of two, at least 2.
- EXPECT_WORDS, 8, words to capture per run; range 1..255.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle arm pulse; clears FIFO, counters and flags.
- in_data  in  DATA_W  result word from output selection.
- in_ready  in  1  one-cycle strobe; in_data is valid in the same cycle.
- out_data  out  DATA_W  FIFO head word.
- out_valid  out  1  out_data holds an unread word.
- out_ack  in  1  host accepts out_data this cycle.
- captured  out  8  words seen this run, including dropped words.
- dropped  out  8  words lost to overflow; saturates at 255.
- overflow  out  1  sticky; set when any word is dropped.
- done  out  1  run complete.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, FIFO empty.
  - out_valid=0, out_data=0, captured=0, dropped=0, overflow=0, done=0.
- States:
  - IDLE: start -> CAPTURE.
  - CAPTURE: on captured reaching EXPECT_WORDS -> FLUSH in the cycle after the last strobe.
  - FLUSH: when the FIFO goes empty -> DONE.
  - DONE: start -> CAPTURE.
- start in any state:
  - Synchronously clears FIFO, captured, dropped, overflow and done; next state is CAPTURE.
  - A word draining at that moment is discarded.
  - An in_ready in the same cycle as start is ignored.
- Capture path:
  - In CAPTURE, each in_ready pushes in_data and increments captured.
  - in_ready in IDLE, FLUSH or DONE is ignored.
- Drain path:
  - out_valid = FIFO not empty. Draining runs in CAPTURE, FLUSH and DONE.
  - The FIFO is show-ahead: out_data equals the head word in the same cycle out_valid is high.
  - out_data stays stable until ack.
  - out_ack with out_valid=1 pops. out_ack with out_valid=0 has no effect.
- Latency: a push at cycle N gives out_valid=1 at cycle N+1 when the FIFO was empty.
- Full boundary:
  - in_ready while full with no pop in that cycle: the word is discarded, captured increments, dropped increments, overflow is set.
  - Push and pop in the same cycle while full: both are accepted and the FIFO stays full.
- Empty boundary: push and pop in the same cycle while empty: only the push takes effect. The pop is not possible because out_valid=0.
- Pointers: wrap modulo DEPTH. The count register is log2(DEPTH)+1 bits wide so full and empty are distinguishable.
- done: goes to 1 on entering DONE and holds until start or reset.

Optional Feature:
- Macro: RESULT_COLLECTOR_CHECKSUM_EN.
- With the macro defined:
  - Adds output port checksum (DATA_W).
  - checksum is the modulo-2^DATA_W sum of accepted (non-dropped) words.
  - Cleared to 0 on reset and on start; updated the cycle after each push.
- Without the macro: the port and its adder are absent; all other behaviour is identical.

Decomposition:
- Package neural_engine_pkg holds:
  - collector_state_t enum: IDLE, CAPTURE, FLUSH, DONE.
  - RESULT_W constant = 16.
- Sub-module result_fifo:
  - Synchronous show-ahead FIFO parameterised by DATA_W and DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty, clear, count.
  - Instantiated once.

Test Plan:
- Reset then start, 8 strobes of 0x0001..0x0008 with out_ack held 1 -> out_data sequence 0x0001..0x0008, captured=8, dropped=0, done=1 after the last pop.
- DEPTH=16, out_ack=0, EXPECT_WORDS=20, 20 strobes -> FIFO holds the first 16, dropped=4, overflow=1; draining then yields exactly the first 16 words in order.
- FIFO full, in_ready and out_ack in the same cycle with data 0xBEEF -> no drop; 0xBEEF is read last; dropped unchanged.
- Mid-run start after 3 of 8 words -> captured=0, out_valid=0 next cycle, overflow cleared, state CAPTURE.
- reset_n asserted asynchronously mid-FLUSH -> all outputs 0 immediately, without a clock edge.
- With RESULT_COLLECTOR_CHECKSUM_EN: words 0xFFFF, 0x0002 -> checksum=0x0001.
